quad_input_filter: RTL and testbench

Multi-channel front end for incremental-encoder inputs. Each channel takes one raw A/B pin pair and passes it through a configurable metastability synchroniser and a stable-count glitch filter. It outputs a clean 2-bit state, a change strobe, and illegal-transition flags (both bits changing at once).
Sits between the encoder pins and the quadrature decoder/counter, replacing the plain 2-bit input register.

---
 rtl/quad_pkg.sv | 12 +
 rtl/quad_filter_ch.sv | 91 +++++++++
 rtl/quad_input_filter.sv | 35 +++
 tb/tb_quad_input_filter.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/quad_pkg.sv
// Shared constants and helpers for the quadrature input filter slice.
package quad_pkg;

    localparam int PAIR_W = 2;
    localparam int A_BIT  = 0;
    localparam int B_BIT  = 1;

    function automatic int cnt_width(input int len);
        return $clog2(len + 1);
    endfunction

endpackage

// File: rtl/quad_filter_ch.sv
// One encoder channel: A/B synchroniser, stable-count glitch filter, illegal-step detection.
module quad_filter_ch
    import quad_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [PAIR_W-1:0] pin,
    input  logic              err_clr,
    output logic [PAIR_W-1:0] state,
    output logic              chg,
    output logic              err_pulse,
    output logic              err_sticky
);

    localparam int               CNT_W    = cnt_width(FILTER_LEN);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(FILTER_LEN);

    logic [SYNC_STAGES-1:0][PAIR_W-1:0] sync_q, sync_d;
    logic [PAIR_W-1:0]                  s;
    logic [PAIR_W-1:0]                  cand_q, cand_d;
    logic [CNT_W-1:0]                   cnt_q, cnt_d;
    logic [CNT_W-1:0]                   n;
    logic [PAIR_W-1:0]                  out_q, out_d;
    logic                               chg_q, chg_d;
    logic                               err_pulse_q, err_pulse_d;
    logic                               err_sticky_q, err_sticky_d;
    logic                               primed_q, primed_d;
    logic                               update;
    logic                               both_flip;

    assign s = sync_q[SYNC_STAGES-1];

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sync_d    = {sync_q[SYNC_STAGES-2:0], pin};
        cand_d    = s;
        n         = (s != cand_q) ? CNT_W'(1) : cnt_q + CNT_W'(1);
        update    = 1'b0;
        cnt_d     = '0;
        out_d     = out_q;
        both_flip = (s[A_BIT] != out_q[A_BIT]) && (s[B_BIT] != out_q[B_BIT]);

        if (s != out_q) begin
            if (n == CNT_DONE) begin
                update = 1'b1;
                out_d  = s;
            end else begin
                cnt_d = n;
            end
        end

        // The first acceptance after reset only arms the checker; pins resting at 11 are not an error.
        chg_d        = update;
        err_pulse_d  = update && primed_q && both_flip;
        primed_d     = primed_q | update;
        err_sticky_d = err_pulse_d | (err_sticky_q & ~err_clr);
    end

    // NOTE: reset is synchronous, so rst is sampled on the edge and stays out of the event list.
    // NOTE: state flops use non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_q       <= '0;
            cand_q       <= '0;
            cnt_q        <= '0;
            out_q        <= '0;
            chg_q        <= 1'b0;
            err_pulse_q  <= 1'b0;
            err_sticky_q <= 1'b0;
            primed_q     <= 1'b0;
        end else begin
            sync_q       <= sync_d;
            cand_q       <= cand_d;
            cnt_q        <= cnt_d;
            out_q        <= out_d;
            chg_q        <= chg_d;
            err_pulse_q  <= err_pulse_d;
            err_sticky_q <= err_sticky_d;
            primed_q     <= primed_d;
        end
    end

    assign state      = out_q;
    assign chg        = chg_q;
    assign err_pulse  = err_pulse_q;
    assign err_sticky = err_sticky_q;

endmodule

// File: rtl/quad_input_filter.sv
// Multi-channel encoder front end: one quad_filter_ch per A/B pin pair.
module quad_input_filter
    import quad_pkg::*;
#(
    parameter int CHANNELS    = 2,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [PAIR_W*CHANNELS-1:0] inQ,
    input  logic                       err_clr,
    output logic [PAIR_W*CHANNELS-1:0] outQ,
    output logic [CHANNELS-1:0]        chg,
    output logic [CHANNELS-1:0]        err_pulse,
    output logic [CHANNELS-1:0]        err_sticky
);

    for (genvar k = 0; k < CHANNELS; k++) begin : g_ch
        quad_filter_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .pin        (inQ[PAIR_W*k +: PAIR_W]),
            .err_clr    (err_clr),
            .state      (outQ[PAIR_W*k +: PAIR_W]),
            .chg        (chg[k]),
            .err_pulse  (err_pulse[k]),
            .err_sticky (err_sticky[k])
        );
    end

endmodule

// File: tb/tb_quad_input_filter.sv
// Directed bench: default 2-channel instance plus a 4-channel, 3-stage, unfiltered instance.
module tb_quad_input_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       err_clr;
    logic [3:0] pins;
    logic [3:0] outs;
    logic [1:0] chg, err_pulse, err_sticky;

    logic [7:0] pins4;
    logic [7:0] outs4;
    logic [3:0] chg4, err_pulse4, err_sticky4;

    int n_tests = 0;
    int n_fail  = 0;

    quad_input_filter dut (
        .clk        (clk),
        .rst        (rst),
        .inQ        (pins),
        .err_clr    (err_clr),
        .outQ       (outs),
        .chg        (chg),
        .err_pulse  (err_pulse),
        .err_sticky (err_sticky)
    );

    quad_input_filter #(
        .CHANNELS    (4),
        .SYNC_STAGES (3),
        .FILTER_LEN  (1)
    ) dut4 (
        .clk        (clk),
        .rst        (rst),
        .inQ        (pins4),
        .err_clr    (err_clr),
        .outQ       (outs4),
        .chg        (chg4),
        .err_pulse  (err_pulse4),
        .err_sticky (err_sticky4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick(input int n = 1);
        repeat (n) @(negedge clk);
    endtask

    logic [1:0] bounce [8] = '{2'b10, 2'b00, 2'b10, 2'b00, 2'b10, 2'b10, 2'b10, 2'b10};
    logic [7:0] hist [0:199];
    int         trans [4];
    int         seen  [4];

    initial begin
        rst     = 1'b0;
        err_clr = 1'b0;
        pins    = '0;
        pins4   = '0;

        // Reset state and single-step latency
        tick(3);
        check("rst_out",    32'(outs),       32'h0);
        check("rst_chg",    32'(chg),        32'h0);
        check("rst_errp",   32'(err_pulse),  32'h0);
        check("rst_errs",   32'(err_sticky), 32'h0);
        check("rst_out4",   32'(outs4),      32'h0);
        rst = 1'b1;
        tick(2);
        pins[1:0] = 2'b01;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("lat_out0", 32'(outs[1:0]),   (i == 6) ? 32'h1 : 32'h0);
            check("lat_chg0", 32'(chg[0]),      (i == 6) ? 32'h1 : 32'h0);
            check("lat_errp", 32'(err_pulse),   32'h0);
        end
        tick();
        check("lat_chg_drop", 32'(chg),       32'h0);
        check("lat_hold",     32'(outs[1:0]), 32'h1);

        // Glitch of 3 cycles is rejected
        pins[1:0] = 2'b11;
        tick(3);
        pins[1:0] = 2'b01;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("glitch_out", 32'(outs[1:0]), 32'h1);
            check("glitch_chg", 32'(chg),       32'h0);
            check("glitch_err", 32'(err_pulse), 32'h0);
        end

        // Bounce on ch1: only the final run of four 10 samples is accepted
        for (int j = 0; j < 12; j++) begin
            pins[3:2] = (j < 8) ? bounce[j] : 2'b10;
            tick();
            check("bounce_out1", 32'(outs[3:2]),    (j + 1 >= 10) ? 32'h2 : 32'h0);
            check("bounce_chg1", 32'(chg[1]),       (j + 1 == 10) ? 32'h1 : 32'h0);
            check("bounce_errp", 32'(err_pulse[1]), 32'h0);
            check("bounce_out0", 32'(outs[1:0]),    32'h1);
        end

        // Illegal transition on primed ch0, err_clr vs new error, err_clr alone
        pins[1:0] = 2'b00;
        tick(8);
        check("ill_pre_out",  32'(outs[1:0]),  32'h0);
        check("ill_pre_errs", 32'(err_sticky), 32'h0);
        pins[1:0] = 2'b11;
        tick(5);
        check("ill_early",    32'(outs[1:0]),     32'h0);
        tick();
        check("ill_out",      32'(outs[1:0]),     32'h3);
        check("ill_chg",      32'(chg[0]),        32'h1);
        check("ill_errp",     32'(err_pulse[0]),  32'h1);
        check("ill_errs",     32'(err_sticky[0]), 32'h1);
        tick(4);
        check("ill_errp_drop", 32'(err_pulse[0]),  32'h0);
        check("ill_errs_hold", 32'(err_sticky[0]), 32'h1);
        pins[1:0] = 2'b00;
        tick(5);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("ill2_out",      32'(outs[1:0]),     32'h0);
        check("ill2_errp",     32'(err_pulse[0]),  32'h1);
        check("ill2_set_wins", 32'(err_sticky[0]), 32'h1);
        tick();
        check("ill2_errs_hold", 32'(err_sticky[0]), 32'h1);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        check("clr_errs",  32'(err_sticky), 32'h0);
        check("clr_errp",  32'(err_pulse),  32'h0);

        // Pins at 11 through reset release: no error on the first acceptance
        pins = 4'b1111;
        rst  = 1'b0;
        tick(3);
        check("prm_rst_out",  32'(outs),       32'h0);
        check("prm_rst_chg",  32'(chg),        32'h0);
        check("prm_rst_errs", 32'(err_sticky), 32'h0);
        rst = 1'b1;
        for (int i = 1; i <= 6; i++) begin
            tick();
            check("prm_out",  32'(outs),       (i == 6) ? 32'hF : 32'h0);
            check("prm_chg",  32'(chg),        (i == 6) ? 32'h3 : 32'h0);
            check("prm_errp", 32'(err_pulse),  32'h0);
            check("prm_errs", 32'(err_sticky), 32'h0);
        end

        // Four channels, unfiltered: output is the pin value from three ticks earlier
        for (int c = 0; c < 4; c++) begin
            trans[c] = 0;
            seen[c]  = 0;
        end
        for (int t = 0; t < 200; t++) hist[t] = 8'h00;
        for (int t = 1; t <= 154; t++) begin
            if (t <= 150) begin
                for (int c = 0; c < 4; c++) begin
                    int r;
                    r = int'($urandom_range(0, 2));
                    if (r == 1) begin
                        pins4[2*c] = ~pins4[2*c];
                        trans[c]++;
                    end else if (r == 2) begin
                        pins4[2*c+1] = ~pins4[2*c+1];
                        trans[c]++;
                    end
                end
            end
            hist[t] = pins4;
            tick();
            check("sweep_out",  32'(outs4),      (t > 3) ? 32'(hist[t-3]) : 32'h0);
            check("sweep_errp", 32'(err_pulse4), 32'h0);
            for (int c = 0; c < 4; c++) seen[c] += int'(chg4[c]);
        end
        for (int c = 0; c < 4; c++) check("sweep_chg_cnt", 32'(seen[c]), 32'(trans[c]));
        check("sweep_errs", 32'(err_sticky4), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
